// File: rtl/deser400_pd_pkg.sv
// Shared definitions for the deser400 phase-detector sequencer and its scheduler.
package deser400_pd_pkg;

  typedef logic [1:0] pd_state_t;

  localparam pd_state_t ST_IDLE = 2'd0;
  localparam pd_state_t ST_TRIG = 2'd1;
  localparam pd_state_t ST_WAIT = 2'd2;

  // CLK80 cycles from trig sample until the sequencer is back in IDLE.
  localparam int SEQ_LEN_DEF = 6;

endpackage

// File: rtl/pd_next_chan.sv
// Finds the lowest set bit of a channel mask strictly above the current channel,
// or the lowest set bit overall when a round is just starting.
module pd_next_chan
  import deser400_pd_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic [NCH-1:0] i_mask,
  input  logic [CW-1:0]  i_cur,
  input  logic           i_from_start,
  output logic [CW-1:0]  o_nxt,
  output logic           o_found
);

  // Scan downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    o_nxt   = '0;
    o_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_from_start || (i > int'(i_cur)))) begin
        o_nxt   = CW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_detector_sched.sv
// Calibration round scheduler: hands the shared phase-detector sequencer to each
// enabled channel in ascending order, one trig per channel, on period expiry or force.
module phase_detector_sched
  import deser400_pd_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CW      = 2,
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter int PER_W   = 16
) (
  input  logic             i_clk80,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic [PER_W-1:0] i_period,
  input  logic [NCH-1:0]   i_ch_ena,
  input  logic             i_force,
  output logic             o_trig,
  output logic [CW-1:0]    o_sel,
  output logic             o_sel_valid,
  output logic             o_busy,
  output logic             o_round_done,
  output logic [7:0]       o_round_cnt,
  output logic [1:0]       o_dbg_state
);

  // Handshake: there is no back-pressure. o_trig is a single-cycle start strobe the
  // sequencer must accept; o_sel is owned by the sequencer whenever o_sel_valid=1.

  localparam int WCW = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;

  pd_state_t        r_state;
  pd_state_t        w_next;
  logic [PER_W-1:0] r_timer;
  logic [NCH-1:0]   r_mask;
  logic [CW-1:0]    r_ptr;
  logic [WCW-1:0]   r_wcnt;
  logic             r_force_pend;
  logic             r_round_done;
  logic [7:0]       r_round_cnt;

  logic             w_periodic;
  logic             w_expire;
  logic             w_start;
  logic             w_last_wait;
  logic             w_in_idle;
  logic [NCH-1:0]   w_nc_mask;
  logic [CW-1:0]    w_nc_nxt;
  logic             w_nc_found;

  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_periodic  = i_run && (i_period != '0);
  assign w_expire    = w_periodic && (r_timer == (i_period - PER_W'(1)));
  assign w_start     = w_in_idle && (i_force || r_force_pend || w_expire);
  assign w_last_wait = (r_state == ST_WAIT) && (r_wcnt == WCW'(SEQ_LEN - 2));

  // In IDLE the live enable mask is searched from the bottom; mid-round the latched one.
  assign w_nc_mask = w_in_idle ? i_ch_ena : r_mask;

  pd_next_chan #(
    .NCH (NCH),
    .CW  (CW)
  ) u_next_chan (
    .i_mask       (w_nc_mask),
    .i_cur        (r_ptr),
    .i_from_start (w_in_idle),
    .o_nxt        (w_nc_nxt),
    .o_found      (w_nc_found)
  );

  always_ff @(posedge i_clk80 or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start && w_nc_found) w_next = ST_TRIG;
      ST_TRIG: w_next = ST_WAIT;
      ST_WAIT: if (w_last_wait) w_next = w_nc_found ? ST_TRIG : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_trig       = (r_state == ST_TRIG);
    o_sel_valid  = (r_state == ST_TRIG) || (r_state == ST_WAIT);
    o_busy       = !w_in_idle;
    o_sel        = r_ptr;
    o_round_done = r_round_done;
    o_round_cnt  = r_round_cnt;
    o_dbg_state  = r_state;
  end

  always_ff @(posedge i_clk80 or posedge i_reset) begin
    if (i_reset) begin
      r_timer      <= '0;
      r_mask       <= '0;
      r_ptr        <= '0;
      r_wcnt       <= '0;
      r_force_pend <= 1'b0;
      r_round_done <= 1'b0;
      r_round_cnt  <= '0;
    end else begin
      r_round_done <= 1'b0;
      // Forces arriving during a round collapse into one pending request.
      if (!w_in_idle && i_force) r_force_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_mask       <= i_ch_ena;
            r_timer      <= '0;
            r_force_pend <= 1'b0;
            if (w_nc_found) r_ptr <= w_nc_nxt;
          end else if (w_periodic) begin
            r_timer <= r_timer + PER_W'(1);
          end else begin
            r_timer <= '0;
          end
        end
        ST_TRIG: r_wcnt <= '0;
        ST_WAIT: begin
          r_wcnt <= r_wcnt + WCW'(1);
          if (w_last_wait) begin
            if (w_nc_found) begin
              r_ptr <= w_nc_nxt;
            end else begin
              r_round_done <= 1'b1;
              r_round_cnt  <= r_round_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_detector_sched.sv
// Bench for phase_detector_sched: directed scenarios plus random traffic against a
// round-list reference model and a simple sequencer occupancy model.
module tb_phase_detector_sched;
  import deser400_pd_pkg::*;

  localparam int NCH     = 4;
  localparam int CW      = 2;
  localparam int SEQ_LEN = 6;
  localparam int PER_W   = 16;

  logic             clk80;
  logic             reset;
  logic             run;
  logic [PER_W-1:0] period;
  logic [NCH-1:0]   ch_ena;
  logic             frc;
  logic             trig;
  logic [CW-1:0]    sel;
  logic             sel_valid;
  logic             busy;
  logic             round_done;
  logic [7:0]       round_cnt;
  logic [1:0]       dbg_state;

  phase_detector_sched #(
    .NCH(NCH), .CW(CW), .SEQ_LEN(SEQ_LEN), .PER_W(PER_W)
  ) dut (
    .i_clk80      (clk80),
    .i_reset      (reset),
    .i_run        (run),
    .i_period     (period),
    .i_ch_ena     (ch_ena),
    .i_force      (frc),
    .o_trig       (trig),
    .o_sel        (sel),
    .o_sel_valid  (sel_valid),
    .o_busy       (busy),
    .o_round_done (round_done),
    .o_round_cnt  (round_cnt),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk80 = 1'b0;
  always #5 clk80 = ~clk80;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_done = 0;
  bit busy_seen;
  int trig_cyc_q[$];
  int trig_sel_q[$];
  int done_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a round is the list of channels enabled at its start; the
  // position inside the round is an offset t from its first trig cycle.
  bit            m_in_round;
  int            m_t;
  int            m_chans[$];
  bit            m_pend;
  logic [15:0]   m_timer;
  bit            m_done;
  logic [7:0]    m_cnt;
  logic [CW-1:0] m_last_sel;

  // Sequencer occupancy model: busy for SEQ_LEN-1 cycles after accepting a trig.
  int            seq_cnt;
  logic [CW-1:0] seq_sel;

  function automatic void model_reset();
    m_in_round = 1'b0;
    m_t        = 0;
    m_chans.delete();
    m_pend     = 1'b0;
    m_timer    = '0;
    m_done     = 1'b0;
    m_cnt      = '0;
    m_last_sel = '0;
    seq_cnt    = 0;
    seq_sel    = '0;
  endfunction

  function automatic void model_step();
    bit per;
    m_done = 1'b0;
    if (m_in_round) begin
      if (frc) m_pend = 1'b1;
      m_t++;
      if (m_t == m_chans.size() * SEQ_LEN) begin
        m_in_round = 1'b0;
        m_done     = 1'b1;
        m_cnt      = m_cnt + 8'd1;
      end
    end else begin
      per = run && (period != 0);
      if (frc || m_pend || (per && (m_timer == period - 16'd1))) begin
        m_timer = '0;
        m_pend  = 1'b0;
        m_chans.delete();
        for (int i = 0; i < NCH; i++) if (ch_ena[i]) m_chans.push_back(i);
        if (m_chans.size() > 0) begin
          m_in_round = 1'b1;
          m_t        = 0;
        end
      end else begin
        m_timer = per ? (m_timer + 16'd1) : 16'd0;
      end
    end
    if (m_in_round) m_last_sel = CW'(m_chans[m_t / SEQ_LEN]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk80);
    if (!reset) model_step();
    #1;
    cyc++;
    if (reset) begin
      model_reset();
      chk("rst_trig", trig, 0);
      chk("rst_sel", sel, 0);
      chk("rst_sel_valid", sel_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_round_done", round_done, 0);
      chk("rst_round_cnt", round_cnt, 0);
    end else begin
      chk("trig", trig, (m_in_round && (m_t % SEQ_LEN == 0)));
      chk("sel_valid", sel_valid, m_in_round);
      chk("busy", busy, m_in_round);
      chk("sel", sel, m_last_sel);
      chk("round_done", round_done, m_done);
      chk("round_cnt", round_cnt, m_cnt);
      if (seq_cnt == 0) begin
        if (trig) begin
          seq_cnt = SEQ_LEN - 1;
          seq_sel = sel;
        end
      end else begin
        chk("seq_trig_not_idle", trig, 0);
        chk("seq_sel_stable", sel, seq_sel);
        seq_cnt--;
      end
      if (trig) begin
        trig_cyc_q.push_back(cyc);
        trig_sel_q.push_back(int'(sel));
      end
      if (round_done) begin
        done_cyc_q.push_back(cyc);
        n_done++;
      end
      if (busy) busy_seen = 1'b1;
    end
  endtask

  task automatic pulse_force();
    frc = 1'b1;
    tick();
    frc = 1'b0;
  endtask

  task automatic clear_log();
    trig_cyc_q.delete();
    trig_sel_q.delete();
    done_cyc_q.delete();
    busy_seen = 1'b0;
  endtask

  task automatic wait_done(input int n, input int max_cyc);
    int start;
    int k;
    start = n_done;
    k = 0;
    while ((n_done - start < n) && (k < max_cyc)) begin
      tick();
      k++;
    end
    chk("wait_done", n_done - start, n);
  endtask

  // ---------------- stimulus ----------------
  int fc;
  int s;
  int c0;

  initial begin
    reset  = 1'b1;
    run    = 1'b0;
    period = '0;
    ch_ena = '0;
    frc    = 1'b0;
    model_reset();
    clear_log();
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();

    // 1: forced round over all four channels.
    ch_ena = 4'b1111;
    clear_log();
    pulse_force();
    fc = cyc;
    wait_done(1, 100);
    chk("t1_trig_n", trig_cyc_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < trig_cyc_q.size()) begin
        chk("t1_trig_cyc", trig_cyc_q[i], fc + SEQ_LEN * i);
        chk("t1_trig_sel", trig_sel_q[i], i);
      end
    end
    if (done_cyc_q.size() > 0) chk("t1_done_cyc", done_cyc_q[0], fc + 4 * SEQ_LEN);
    chk("t1_round_cnt", round_cnt, 1);
    repeat (5) tick();

    // 2: periodic rounds, period 100, channels 0 and 2.
    clear_log();
    s      = cyc;
    run    = 1'b1;
    period = 16'd100;
    ch_ena = 4'b0101;
    wait_done(3, 600);
    run = 1'b0;
    chk("t2_trig_n", trig_cyc_q.size(), 6);
    chk("t2_done_n", done_cyc_q.size(), 3);
    if (trig_cyc_q.size() == 6 && done_cyc_q.size() == 3) begin
      chk("t2_first_trig", trig_cyc_q[0], s + 100);
      for (int k = 0; k < 3; k++) begin
        chk("t2_sel_a", trig_sel_q[2*k], 0);
        chk("t2_sel_b", trig_sel_q[2*k+1], 2);
        chk("t2_spacing", trig_cyc_q[2*k+1], trig_cyc_q[2*k] + SEQ_LEN);
        chk("t2_done", done_cyc_q[k], trig_cyc_q[2*k] + 2 * SEQ_LEN);
        if (k < 2) chk("t2_period", trig_cyc_q[2*k+2], done_cyc_q[k] + 100);
      end
    end
    period = '0;
    repeat (5) tick();

    // 3: forces while busy merge into exactly one extra round.
    clear_log();
    c0     = int'(round_cnt);
    ch_ena = 4'b0010;
    pulse_force();
    repeat (2) tick();
    pulse_force();
    tick();
    pulse_force();
    wait_done(2, 60);
    repeat (20) tick();
    chk("t3_trig_n", trig_cyc_q.size(), 2);
    if (trig_cyc_q.size() >= 2 && done_cyc_q.size() >= 1)
      chk("t3_back_to_back", trig_cyc_q[1], done_cyc_q[0] + 1);
    chk("t3_round_cnt", round_cnt, 8'(c0 + 2));

    // 4: empty mask with force, and run with period 0, do nothing.
    clear_log();
    c0     = int'(round_cnt);
    ch_ena = 4'b0000;
    pulse_force();
    repeat (10) tick();
    run    = 1'b1;
    period = '0;
    repeat (50) tick();
    run = 1'b0;
    chk("t4_trig_n", trig_cyc_q.size(), 0);
    chk("t4_done_n", done_cyc_q.size(), 0);
    chk("t4_busy_seen", busy_seen, 0);
    chk("t4_round_cnt", round_cnt, c0);

    // 5: asynchronous reset during the wait phase of channel 1.
    ch_ena = 4'b1111;
    clear_log();
    pulse_force();
    repeat (SEQ_LEN + 2) tick();
    chk("t5_pre_sel", sel, 1);
    chk("t5_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("t5_async_trig", trig, 0);
    chk("t5_async_sel_valid", sel_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_cnt", round_cnt, 0);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clear_log();
    pulse_force();
    wait_done(1, 100);
    chk("t5_trig_n", trig_cyc_q.size(), 4);
    if (trig_sel_q.size() > 0) chk("t5_first_sel", trig_sel_q[0], 0);
    chk("t5_round_cnt", round_cnt, 1);

    // 6: enable mask toggled throughout a round has no effect on it.
    clear_log();
    ch_ena = 4'b1111;
    pulse_force();
    for (int i = 0; i < 20; i++) begin
      ch_ena = 4'($urandom_range(0, 15));
      tick();
    end
    wait_done(1, 100);
    chk("t6_trig_n", trig_cyc_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < trig_sel_q.size()) chk("t6_sel_order", trig_sel_q[i], i);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) begin
        run    = 1'($urandom_range(0, 1));
        period = 16'($urandom_range(0, 40));
      end
      ch_ena = 4'($urandom_range(0, 15));
      frc    = ($urandom_range(0, 19) == 0);
      tick();
    end
    frc = 1'b0;
    run = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
